// File: rtl/vint_pwm_bank_if.sv
// Control and waveform bundle of the multi-channel vibration/drive output bank.
// The controller drives configuration through master; the generator bank is the slave.
interface vint_pwm_bank_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8
);
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS-1:0]       mode;
  logic [CHANNELS*CNT_W-1:0] period;
  logic [CHANNELS*CNT_W-1:0] duty;
  logic [CHANNELS-1:0]       v;
  logic [CHANNELS-1:0]       wrap;

  modport master (output en, mode, period, duty, input v, wrap);
  modport slave  (input en, mode, period, duty, output v, wrap);
endinterface

// File: rtl/vint_pwm_bank.sv
// Multi-channel square/PWM output generator sharing one clock-enable prescaler.
// Period, duty and mode are shadowed per channel and only take effect at start or wrap.
module vint_pwm_bank #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned PRESCALE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  vint_pwm_bank_if.slave bus
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CW1   = CNT_W + 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick_c;

  logic [CHANNELS-1:0] active_q, active_d;
  logic [CHANNELS-1:0] m_q, m_d;
  logic [CHANNELS-1:0] v_q, v_d;
  logic [CHANNELS-1:0] wrap_q, wrap_d;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][CNT_W-1:0] p_q, p_d;
  logic [CHANNELS-1:0][CNT_W-1:0] d_q, d_d;

  logic [CHANNELS-1:0][CNT_W-1:0] in_p_c, in_d_c;
  logic [CHANNELS-1:0]            start_hi_c;

  assign in_p_c = bus.period;
  assign in_d_c = bus.duty;

  // Free-running prescaler; its phase is independent of the channel enables.
  always_comb begin
    tick_c    = (pre_cnt_q == PRE_LAST);
    pre_cnt_d = tick_c ? '0 : pre_cnt_q + PRE_W'(1);
  end

  // PWM level for the first tick of a new period, taken from the incoming configuration.
  always_comb begin
    start_hi_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      start_hi_c[i] = (in_p_c[i] != '0) && (in_d_c[i] != '0);
    end
  end

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    d_d      = d_q;
    m_d      = m_q;
    v_d      = v_q;
    wrap_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!bus.en[i]) begin
        active_d[i] = 1'b0;
        cnt_d[i]    = '0;
        v_d[i]      = 1'b0;
      end else if (!active_q[i]) begin
        active_d[i] = 1'b1;
        p_d[i]      = in_p_c[i];
        d_d[i]      = in_d_c[i];
        m_d[i]      = bus.mode[i];
        cnt_d[i]    = '0;
        v_d[i]      = bus.mode[i] & start_hi_c[i];
      end else if (tick_c) begin
        if (p_q[i] == '0) begin
          // Zero period parks the output low but keeps sampling new configuration.
          p_d[i]   = in_p_c[i];
          d_d[i]   = in_d_c[i];
          m_d[i]   = bus.mode[i];
          cnt_d[i] = '0;
          v_d[i]   = 1'b0;
        end else if (cnt_q[i] == p_q[i] - CNT_W'(1)) begin
          p_d[i]    = in_p_c[i];
          d_d[i]    = in_d_c[i];
          m_d[i]    = bus.mode[i];
          cnt_d[i]  = '0;
          wrap_d[i] = 1'b1;
          v_d[i]    = bus.mode[i] ? start_hi_c[i] : ~v_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
          if (m_q[i]) begin
            v_d[i] = (CW1'(cnt_q[i]) + CW1'(1)) < CW1'(d_q[i]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      active_q  <= '0;
      cnt_q     <= '0;
      p_q       <= '0;
      d_q       <= '0;
      m_q       <= '0;
      v_q       <= '0;
      wrap_q    <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      d_q       <= d_d;
      m_q       <= m_d;
      v_q       <= v_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.v    = v_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_vint_pwm_bank.sv
// Bench for vint_pwm_bank: fixed waveform table, directed corner sequences and
// randomized reconfiguration, all checked cycle by cycle against a tick-level channel model.
module tb_vint_pwm_bank;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned PRESCALE = 4;

  logic clk = 1'b0;
  logic rst_n;
  bit   chk_on = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  vint_pwm_bank_if #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) bus ();

  vint_pwm_bank #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .PRESCALE(PRESCALE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int ch, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s ch%0d: got %0d, expected %0d", name, ch, act, exp);
    else n_pass++;
  endtask

  // Reference: each channel tracks its position inside the current period and the
  // configuration latched for it; tick k after reset falls on clock edge k*PRESCALE-1.
  typedef struct {
    bit run;
    int pos;
    int p;
    int d;
    bit m;
    bit v;
    bit w;
  } mdl_t;

  mdl_t mdl [CHANNELS];
  int   edge_n;

  function automatic void model_step(input int c, input bit tk);
    int  np, nd;
    bit  nm;
    np = int'(bus.period[c*CNT_W +: CNT_W]);
    nd = int'(bus.duty[c*CNT_W +: CNT_W]);
    nm = bus.mode[c];
    mdl[c].w = 1'b0;
    if (!bus.en[c]) begin
      mdl[c].run = 1'b0;
      mdl[c].pos = 0;
      mdl[c].v   = 1'b0;
    end else if (!mdl[c].run) begin
      mdl[c].run = 1'b1;
      mdl[c].p = np; mdl[c].d = nd; mdl[c].m = nm;
      mdl[c].pos = 0;
      mdl[c].v   = nm && np > 0 && nd > 0;
    end else if (tk) begin
      if (mdl[c].p == 0) begin
        mdl[c].p = np; mdl[c].d = nd; mdl[c].m = nm;
        mdl[c].pos = 0;
        mdl[c].v   = 1'b0;
      end else if (mdl[c].pos + 1 == mdl[c].p) begin
        mdl[c].p = np; mdl[c].d = nd; mdl[c].m = nm;
        mdl[c].pos = 0;
        mdl[c].w   = 1'b1;
        mdl[c].v   = nm ? (np > 0 && nd > 0) : !mdl[c].v;
      end else begin
        mdl[c].pos = mdl[c].pos + 1;
        // PWM is high for positions 0..min(D,P)-1 of each period.
        if (mdl[c].m) mdl[c].v = mdl[c].pos < mdl[c].d;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit tk;
    if (!rst_n) begin
      edge_n = 0;
      for (int c = 0; c < CHANNELS; c++) mdl[c] = '{default: 0};
    end else begin
      tk = (edge_n % int'(PRESCALE)) == int'(PRESCALE) - 1;
      edge_n++;
      for (int c = 0; c < CHANNELS; c++) model_step(c, tk);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int c = 0; c < CHANNELS; c++) begin
        check("v", c, 32'(bus.v[c]), 32'(mdl[c].v));
        check("wrap", c, 32'(bus.wrap[c]), 32'(mdl[c].w));
      end
    end
  end

  task automatic set_ch(input int c, input bit e, input bit m, input int unsigned p,
                        input int unsigned d);
    bus.en[c]                     = e;
    bus.mode[c]                   = m;
    bus.period[c*CNT_W +: CNT_W]  = CNT_W'(p);
    bus.duty[c*CNT_W +: CNT_W]    = CNT_W'(d);
  endtask

  // Returns at a falling clock edge with reset just released and all channels off,
  // so the next rising edge is edge 0 of the prescaler.
  task automatic restart();
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.en = '0; bus.mode = '0; bus.period = '0; bus.duty = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_ch(input int c, input int n, output int unsigned highs,
                          output int unsigned wraps);
    highs = 0;
    wraps = 0;
    repeat (n) begin
      @(negedge clk);
      highs += 32'(bus.v[c]);
      wraps += 32'(bus.wrap[c]);
    end
  endtask

  typedef struct {
    bit          mode;
    int unsigned period;
    int unsigned duty;
    int unsigned highs;
    int unsigned wraps;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int unsigned highs, wraps;
    int unsigned wq [$];
    int          n;
    bit          found;

    // Expected v-high and wrap counts over 48 clocks from an aligned start.
    vecs[0] = '{mode: 1'b0, period: 3,  duty: 99, highs: 24, wraps: 4};
    vecs[1] = '{mode: 1'b1, period: 10, duty: 3,  highs: 20, wraps: 1};
    vecs[2] = '{mode: 1'b1, period: 10, duty: 0,  highs: 0,  wraps: 1};
    vecs[3] = '{mode: 1'b1, period: 10, duty: 12, highs: 48, wraps: 1};
    vecs[4] = '{mode: 1'b1, period: 0,  duty: 5,  highs: 0,  wraps: 0};
    vecs[5] = '{mode: 1'b0, period: 1,  duty: 0,  highs: 24, wraps: 12};

    bus.en = '0; bus.mode = '0; bus.period = '0; bus.duty = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int c = 0; c < CHANNELS; c++) begin
      check("reset_v", c, 32'(bus.v[c]), 32'd0);
      check("reset_wrap", c, 32'(bus.wrap[c]), 32'd0);
    end
    chk_on = 1'b1;

    for (int i = 0; i < 6; i++) begin
      restart();
      set_ch(0, 1'b1, vecs[i].mode, vecs[i].period, vecs[i].duty);
      count_ch(0, 48, highs, wraps);
      check($sformatf("tbl%0d_highs", i), 0, highs, vecs[i].highs);
      check($sformatf("tbl%0d_wraps", i), 0, wraps, vecs[i].wraps);
    end

    // Shadowing: new config written at cnt=2 only lands at the wrap on edge 39.
    restart();
    set_ch(0, 1'b1, 1'b1, 10, 5);
    repeat (9) @(negedge clk);
    set_ch(0, 1'b1, 1'b1, 4, 1);
    n = 9;
    repeat (51) begin
      @(negedge clk);
      if (bus.wrap[0]) wq.push_back(n);
      n++;
    end
    check("shadow_nwrap", 0, wq.size(), 32'd2);
    check("shadow_wrap0", 0, (wq.size() > 0) ? wq[0] : 32'hFFFF_FFFF, 32'd39);
    check("shadow_wrap1", 0, (wq.size() > 1) ? wq[1] : 32'hFFFF_FFFF, 32'd55);

    // Disable at cnt=5, then restart.
    restart();
    set_ch(0, 1'b1, 1'b1, 10, 3);
    repeat (20) @(negedge clk);
    bus.en[0] = 1'b0;
    @(negedge clk);
    check("dis_v", 0, 32'(bus.v[0]), 32'd0);
    count_ch(0, 60, highs, wraps);
    check("dis_wraps", 0, wraps, 32'd0);
    bus.en[0] = 1'b1;
    @(negedge clk);
    check("restart_v", 0, 32'(bus.v[0]), 32'd1);
    repeat (50) @(negedge clk);

    // Zero period, then period=2 must wrap within three ticks.
    restart();
    set_ch(0, 1'b1, 1'b1, 0, 5);
    count_ch(0, 20, highs, wraps);
    check("p0_highs", 0, highs, 32'd0);
    check("p0_wraps", 0, wraps, 32'd0);
    set_ch(0, 1'b1, 1'b1, 2, 1);
    found = 1'b0;
    for (int k = 0; k < 3 * int'(PRESCALE) && !found; k++) begin
      @(negedge clk);
      if (bus.wrap[0]) found = 1'b1;
    end
    check("p2_wrap_seen", 0, 32'(found), 32'd1);

    // Full-width period: wraps at edges 1019 and 2039.
    restart();
    set_ch(1, 1'b1, 1'b1, 255, 200);
    count_ch(1, 2100, highs, wraps);
    check("p255_wraps", 1, wraps, 32'd2);

    // Reset mid-operation clears immediately, then channels restart.
    restart();
    set_ch(0, 1'b1, 1'b0, 2, 0);
    set_ch(1, 1'b1, 1'b1, 5, 2);
    set_ch(2, 1'b1, 1'b1, 3, 3);
    set_ch(3, 1'b1, 1'b1, 7, 0);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < CHANNELS; c++) begin
      check("midrst_v", c, 32'(bus.v[c]), 32'd0);
      check("midrst_wrap", c, 32'(bus.wrap[c]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_v", 2, 32'(bus.v[2]), 32'd1);
    repeat (100) @(negedge clk);

    // Randomized enables and configuration changes on all channels.
    restart();
    for (int c = 0; c < CHANNELS; c++) set_ch(c, 1'b1, 1'(c), 32'(c + 2), 32'(c));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < CHANNELS; c++) begin
        int unsigned p;
        if ($urandom_range(0, 59) == 0) bus.en[c] = ~bus.en[c];
        if ($urandom_range(0, 19) == 0) begin
          p = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
          set_ch(c, bus.en[c], 1'($urandom_range(0, 1)), p, $urandom_range(0, p + 2));
        end
      end
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
